// File: rtl/mem_readback_streamer.sv
// Sweeps an address range through a registered-read memory and streams
// each word out over valid/ready while summing a 32-bit checksum.
module mem_readback_streamer #(
    parameter int WID_MEM = 1,
    parameter int DEPTH_MEM = 16384,
    localparam int AW = $clog2(DEPTH_MEM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [AW:0]        word_count,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_rdata,
    output logic [WID_MEM-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic [31:0]        checksum
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;

    state_t state;
    state_t state_nx;

    logic [AW-1:0]      addr;
    logic [AW-1:0]      raddr_q;
    logic [AW:0]        issue_left;
    logic [AW:0]        deliver_left;
    logic [WID_MEM-1:0] fifo_mem [2];
    logic               rptr;
    logic               wptr;
    logic [1:0]         fifo_count;
    logic               inflight;
    logic               pop;
    logic               issue;
    logic               accept;
    logic [2:0]         occ;
    logic               unused_base;

    assign unused_base = ^base_addr[31:AW];

    assign pop    = out_valid & out_ready;
    assign accept = (state == IDLE) & start;
    assign occ    = 3'(fifo_count) + 3'(inflight);

    // Issue only if the word can land in the FIFO even with no pop later.
    assign issue = (state == READ) & ~reset
                 & (occ < (3'd2 + 3'(pop)));

    assign mem_raddr = issue ? 32'(addr) : 32'(raddr_q);
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rptr];
    assign out_last  = out_valid & (deliver_left == CNT_ONE);
    assign busy      = (state == READ) | (state == DRAIN);
    assign done      = (state == FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (word_count == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (issue && issue_left == CNT_ONE) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && deliver_left == CNT_ONE) begin
                    state_nx = FINISH;
                end
            end
            FINISH: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr         <= '0;
            raddr_q      <= '0;
            issue_left   <= '0;
            deliver_left <= '0;
            fifo_mem[0]  <= '0;
            fifo_mem[1]  <= '0;
            rptr         <= 1'b0;
            wptr         <= 1'b0;
            fifo_count   <= 2'd0;
            inflight     <= 1'b0;
            checksum     <= '0;
        end else begin
            if (accept) begin
                addr         <= base_addr[AW-1:0];
                issue_left   <= word_count;
                deliver_left <= word_count;
                checksum     <= '0;
            end
            if (issue) begin
                raddr_q    <= addr;
                addr       <= addr + ADDR_ONE;
                issue_left <= issue_left - CNT_ONE;
            end
            inflight <= issue;
            if (inflight) begin
                fifo_mem[wptr] <= mem_rdata;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr         <= ~rptr;
                deliver_left <= deliver_left - CNT_ONE;
                checksum     <= checksum + 32'(out_data);
            end
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Bench for mem_readback_streamer: directed table, hand sequences for
// reset/start corner cases, and random backpressure sweeps vs a model.
module tb_mem_readback_streamer;

    localparam int W = 4;
    localparam int D = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   base_addr;
    logic [AW:0]   word_count;
    logic [31:0]   mem_raddr;
    logic [W-1:0]  mem_rdata;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [31:0]   checksum;

    logic [W-1:0]  ram [D];

    int total = 0;
    int passed = 0;

    mem_readback_streamer #(
        .WID_MEM(W),
        .DEPTH_MEM(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .word_count(word_count),
        .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .done(done),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_raddr[AW-1:0]];

    task automatic check(input string nm, input longint act,
                         input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fill_ram(input int pat);
        for (int i = 0; i < D; i++) begin
            case (pat)
                0: ram[i] = W'(i % 4);
                1: ram[i] = W'(i);
                default: ram[i] = W'($urandom_range(0, D - 1));
            endcase
        end
    endtask

    // One sweep: cycle 0 is the cycle where start is high.
    task automatic run_sweep(input int b, input int n, input bit rnd,
                             input int poke, output logic [31:0] cs,
                             output int done_c);
        int exp_q[$];
        int got_d[$];
        int got_l[$];
        int got_c[$];
        int ra[$];
        logic [31:0] sum_m;
        int c;
        int stall_bad;
        bit stall_pend;
        logic [W-1:0] st_d;
        logic st_l;
        sum_m = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(int'(ram[(b + i) % D]));
            sum_m += 32'(ram[(b + i) % D]);
        end
        stall_bad = 0;
        stall_pend = 0;
        st_d = '0;
        st_l = 1'b0;
        cs = 'x;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 32'(b);
        word_count = (AW + 1)'(n);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        c = 0;
        done_c = -1;
        while (done_c < 0 && c < 400) begin
            @(negedge clk);
            if (c >= 1 && c <= n) ra.push_back(int'(mem_raddr));
            if (c == 1 && n > 0) check("busy_after_start", busy, 1);
            if (stall_pend &&
                (!out_valid || out_data !== st_d || out_last !== st_l))
                stall_bad++;
            stall_pend = out_valid && !out_ready;
            st_d = out_data;
            st_l = out_last;
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(int'(out_last));
                got_c.push_back(c);
            end
            if (done) begin
                done_c = c;
                cs = checksum;
                check("checksum_vs_model", checksum, sum_m);
                check("busy_low_in_done", busy, 0);
            end
            @(posedge clk);
            #1;
            c++;
            start = (c == poke);
            base_addr = (c == poke) ? 32'd9 : 32'(b);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        check("done_seen_in_budget", done_c >= 0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("word_total", got_d.size(), n);
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            check("word_data", got_d[i], exp_q[i]);
            check("word_last", got_l[i], (i == n - 1) ? 1 : 0);
        end
        check("stall_stable", stall_bad, 0);
        if (!rnd) begin
            for (int i = 0; i < n && i < ra.size(); i++)
                check("raddr_seq", ra[i], (b + i) % D);
            if (n > 0 && got_c.size() > 0) begin
                check("first_hs_cycle", got_c[0], 3);
                check("last_hs_cycle", got_c[got_c.size() - 1], n + 2);
            end
        end
    endtask

    typedef struct {
        int          pat;
        int          base;
        int          count;
        bit          rnd;
        logic [31:0] sum;
        int          done_cyc;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] cs;
    int dc;
    int seen;

    initial begin
        vecs[0] = '{0, 0, 8, 1'b0, 32'd12, 11};
        vecs[1] = '{0, 0, 8, 1'b1, 32'd12, -1};
        vecs[2] = '{1, 14, 4, 1'b0, 32'd30, 7};
        vecs[3] = '{1, 0, 0, 1'b0, 32'd0, 1};
        vecs[4] = '{1, 5, 1, 1'b0, 32'd5, 4};
        vecs[5] = '{1, 3, 16, 1'b0, 32'd120, 19};
        vecs[6] = '{1, 15, 2, 1'b0, 32'd15, 5};

        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        out_ready = 1'b1;
        fill_ram(0);
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_raddr", mem_raddr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 0);

        foreach (vecs[k]) begin
            fill_ram(vecs[k].pat);
            run_sweep(vecs[k].base, vecs[k].count, vecs[k].rnd, -1, cs, dc);
            check("table_checksum", cs, vecs[k].sum);
            if (vecs[k].done_cyc >= 0)
                check("table_done_cycle", dc, vecs[k].done_cyc);
        end

        // Reset during cycle 5 of a sweep.
        fill_ram(0);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = 32'd0;
        word_count = 5'd8;
        out_ready = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_raddr", mem_raddr, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || out_valid || busy) seen++;
        end
        check("mid_rst_quiet", seen, 0);
        run_sweep(0, 8, 1'b0, -1, cs, dc);
        check("after_rst_checksum", cs, 12);
        check("after_rst_done_cycle", dc, 11);

        // A second start while busy must be ignored.
        run_sweep(0, 8, 1'b0, 3, cs, dc);
        check("ignored_start_checksum", cs, 12);
        check("ignored_start_done", dc, 11);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || out_valid || busy) seen++;
        end
        check("no_second_sweep", seen, 0);

        for (int r = 0; r < 8; r++) begin
            fill_ram(2);
            run_sweep($urandom_range(0, D - 1), $urandom_range(0, D),
                      1'b1, -1, cs, dc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
